// File: rtl/instr_stream_encoder_if.sv
// Instruction-in handshake plus IMEM write port of instr_stream_encoder.
// The slave modport is the encoder side; the master modport is the instruction source / IMEM side.
interface instr_stream_encoder_if #(
  parameter int ADDR_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [4:0]        in_kind;
  logic [4:0]        in_rd;
  logic [4:0]        in_rs;
  logic [4:0]        in_rt;
  logic [4:0]        in_shamt;
  logic [31:0]       in_imm;
  logic              in_last;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  modport master (
    output in_valid, in_kind, in_rd, in_rs, in_rt, in_shamt, in_imm, in_last,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_valid, in_kind, in_rd, in_rs, in_rt, in_shamt, in_imm, in_last,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/instr_stream_encoder.sv
// Packs mnemonic-level fields into 32-bit MIPS words and writes them to IMEM at an auto-incrementing address.
// Optional build macro INSTR_ENC_LI_EN: kind 27 (LI rt,imm32) expands to LUI + ORI; otherwise kind 27 is illegal.
//
// state  | meaning
// S_RUN  | accepting instructions, one IMEM write per legal accept
// S_LI2  | emitting the ORI half of an LI (LI build only)
// S_FULL | all DEPTH slots written; left only by rst
module instr_stream_encoder #(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0,
  parameter int DEPTH     = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  instr_stream_encoder_if.slave bus,
  output logic                  full,
  output logic                  done,
  output logic                  err
);

  // Encodings match controller_constants.vh so encode and decode agree.
  localparam logic [5:0] OP_RTYPE = 6'h00, OP_REGIMM = 6'h01, OP_J    = 6'h02, OP_JAL  = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04, OP_BNE    = 6'h05, OP_BGTZ = 6'h07, OP_ADDI = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09, OP_SLTI   = 6'h0A, OP_ANDI = 6'h0C, OP_ORI  = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F, OP_LW     = 6'h23, OP_SW   = 6'h2B;

  localparam logic [5:0] FN_SLL = 6'h00, FN_SRL  = 6'h02, FN_SRA = 6'h03, FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20, FN_ADDU = 6'h21, FN_SUB = 6'h22, FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND = 6'h24, FN_OR   = 6'h25, FN_NOR = 6'h27, FN_SLT  = 6'h2A;

  localparam logic [4:0] K_NOP  = 5'd0,  K_ADD  = 5'd1,  K_ADDU  = 5'd2,  K_SUB  = 5'd3;
  localparam logic [4:0] K_SUBU = 5'd4,  K_AND  = 5'd5,  K_OR    = 5'd6,  K_NOR  = 5'd7;
  localparam logic [4:0] K_SLT  = 5'd8,  K_SLL  = 5'd9,  K_SRL   = 5'd10, K_SRA  = 5'd11;
  localparam logic [4:0] K_JR   = 5'd12, K_ADDI = 5'd13, K_ADDIU = 5'd14, K_ANDI = 5'd15;
  localparam logic [4:0] K_ORI  = 5'd16, K_SLTI = 5'd17, K_LUI   = 5'd18, K_LW   = 5'd19;
  localparam logic [4:0] K_SW   = 5'd20, K_BEQ  = 5'd21, K_BNE   = 5'd22, K_BGTZ = 5'd23;
  localparam logic [4:0] K_BGEZ = 5'd24, K_J    = 5'd25, K_JAL   = 5'd26, K_LI   = 5'd27;

  localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(BASE_ADDR + DEPTH - 1);

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_FULL = 2'd1
`ifdef INSTR_ENC_LI_EN
    , S_LI2 = 2'd2
`endif
  } state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] ptr;
  logic              ptr_last;
  logic              ready, accept, kind_li;
  logic              enc_legal;
  logic [31:0]       enc_word, r_base;
  logic              wr_en, wr_last, done_set, done_pend;
  logic [31:0]       wr_data;

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  assign ptr_last = (ptr == LAST_ADDR);
  assign r_base   = {OP_RTYPE, bus.in_rs, bus.in_rt, bus.in_rd, bus.in_shamt, 6'd0};

`ifdef INSTR_ENC_LI_EN
  logic [4:0]  li_rt;
  logic [15:0] li_lo;
  logic        li_last;
  assign kind_li = (bus.in_kind == K_LI);
`else
  logic unused_imm_hi;
  assign kind_li       = 1'b0;
  assign unused_imm_hi = ^bus.in_imm[31:26];
`endif

  // An LI offered with only one free slot is held off rather than split.
  assign ready        = !rst && (state == S_RUN) && !(kind_li && ptr_last);
  assign accept       = bus.in_valid && ready;
  assign bus.in_ready = ready;

  always_comb begin
    enc_legal = 1'b1;
    enc_word  = '0;
    case (bus.in_kind)
      K_NOP:   enc_word = '0;
      K_ADD:   enc_word = r_base | {26'd0, FN_ADD};
      K_ADDU:  enc_word = r_base | {26'd0, FN_ADDU};
      K_SUB:   enc_word = r_base | {26'd0, FN_SUB};
      K_SUBU:  enc_word = r_base | {26'd0, FN_SUBU};
      K_AND:   enc_word = r_base | {26'd0, FN_AND};
      K_OR:    enc_word = r_base | {26'd0, FN_OR};
      K_NOR:   enc_word = r_base | {26'd0, FN_NOR};
      K_SLT:   enc_word = r_base | {26'd0, FN_SLT};
      K_SLL:   enc_word = r_base | {26'd0, FN_SLL};
      K_SRL:   enc_word = r_base | {26'd0, FN_SRL};
      K_SRA:   enc_word = r_base | {26'd0, FN_SRA};
      K_JR:    enc_word = {OP_RTYPE, bus.in_rs, 15'd0, FN_JR};
      K_ADDI:  enc_word = itype(OP_ADDI, bus.in_rs, bus.in_rt, bus.in_imm[15:0]);
      K_ADDIU: enc_word = itype(OP_ADDIU, bus.in_rs, bus.in_rt, bus.in_imm[15:0]);
      K_ANDI:  enc_word = itype(OP_ANDI, bus.in_rs, bus.in_rt, bus.in_imm[15:0]);
      K_ORI:   enc_word = itype(OP_ORI, bus.in_rs, bus.in_rt, bus.in_imm[15:0]);
      K_SLTI:  enc_word = itype(OP_SLTI, bus.in_rs, bus.in_rt, bus.in_imm[15:0]);
      K_LUI:   enc_word = itype(OP_LUI, bus.in_rs, bus.in_rt, bus.in_imm[15:0]);
      K_LW:    enc_word = itype(OP_LW, bus.in_rs, bus.in_rt, bus.in_imm[15:0]);
      K_SW:    enc_word = itype(OP_SW, bus.in_rs, bus.in_rt, bus.in_imm[15:0]);
      K_BEQ:   enc_word = itype(OP_BEQ, bus.in_rs, bus.in_rt, bus.in_imm[15:0]);
      K_BNE:   enc_word = itype(OP_BNE, bus.in_rs, bus.in_rt, bus.in_imm[15:0]);
      K_BGTZ:  enc_word = itype(OP_BGTZ, bus.in_rs, 5'd0, bus.in_imm[15:0]);
      K_BGEZ:  enc_word = itype(OP_REGIMM, bus.in_rs, 5'd1, bus.in_imm[15:0]);
      K_J:     enc_word = {OP_J, bus.in_imm[25:0]};
      K_JAL:   enc_word = {OP_JAL, bus.in_imm[25:0]};
`ifdef INSTR_ENC_LI_EN
      K_LI:    enc_word = itype(OP_LUI, 5'd0, bus.in_rt, bus.in_imm[31:16]);
`endif
      default: enc_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_RUN;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_RUN: begin
`ifdef INSTR_ENC_LI_EN
        if (accept && enc_legal && kind_li)       state_n = S_LI2;
        else if (accept && enc_legal && ptr_last) state_n = S_FULL;
`else
        if (accept && enc_legal && ptr_last) state_n = S_FULL;
`endif
      end
`ifdef INSTR_ENC_LI_EN
      S_LI2:   state_n = ptr_last ? S_FULL : S_RUN;
`endif
      S_FULL:  state_n = S_FULL;
      default: state_n = S_RUN;
    endcase
  end

  always_comb begin
    wr_en    = 1'b0;
    wr_data  = '0;
    wr_last  = 1'b0;
    done_set = 1'b0;
    case (state)
      S_RUN: begin
        wr_en    = accept && enc_legal;
        wr_data  = enc_word;
        wr_last  = bus.in_last && !kind_li;
        done_set = accept && bus.in_last && !kind_li;
      end
`ifdef INSTR_ENC_LI_EN
      S_LI2: begin
        wr_en    = 1'b1;
        wr_data  = itype(OP_ORI, li_rt, li_rt, li_lo);
        wr_last  = li_last;
        done_set = li_last;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= BASE;
      bus.mem_wdata <= '0;
      ptr           <= BASE;
      full          <= 1'b0;
      done_pend     <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
    end else begin
      bus.mem_we <= wr_en;
      done_pend  <= done_set;
      done       <= done_pend;
      if (wr_en) begin
        bus.mem_addr  <= ptr;
        bus.mem_wdata <= wr_data;
        ptr           <= wr_last ? BASE : ptr + 1'b1;
        if (ptr_last) full <= 1'b1;
      end
      if (accept && !enc_legal) err <= 1'b1;
    end
  end

`ifdef INSTR_ENC_LI_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      li_rt   <= '0;
      li_lo   <= '0;
      li_last <= 1'b0;
    end else if (accept && kind_li) begin
      li_rt   <= bus.in_rt;
      li_lo   <= bus.in_imm[15:0];
      li_last <= bus.in_last;
    end
  end
`endif

endmodule

// File: tb/tb_instr_stream_encoder.sv
// Bench for instr_stream_encoder: directed literal cases plus randomized traffic against a word-level model.
// Build with INSTR_ENC_LI_EN defined to also exercise the LI expansion.
module tb_instr_stream_encoder;
  localparam int AW   = 8;
  localparam int BASE = 4;
  localparam int DEP  = 16;
`ifdef INSTR_ENC_LI_EN
  localparam bit LI_EN = 1'b1;
`else
  localparam bit LI_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic full, done, err;
  int   total = 0, bad = 0, cyc = 0, done_cnt = 0;
  bit   chk_en = 1'b0;

  logic [31:0] wlog_data[$];
  int          wlog_addr[$];
  int          wlog_cyc[$];

  // model: words written in current program, pending ORI word, expectations for next cycle
  int          m_used = 0;
  bit          m_full = 0, m_err = 0, m_second = 0, m_second_last = 0, m_done_pend = 0;
  logic [31:0] m_second_word = '0;
  bit          e_we = 0, e_done = 0;
  int          e_addr = BASE;
  logic [31:0] e_data = '0;

  instr_stream_encoder_if #(.ADDR_W(AW)) ifc ();

  instr_stream_encoder #(.ADDR_W(AW), .BASE_ADDR(BASE), .DEPTH(DEP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc),
    .full(full),
    .done(done),
    .err (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] rw(input int rs, input int rt, input int rd, input int sh, input int fn);
    return 32'((rs << 21) + (rt << 16) + (rd << 11) + (sh << 6) + fn);
  endfunction

  function automatic logic [31:0] iw(input int op, input int rs, input int rt, input logic [31:0] imm);
    return 32'((op << 26) + (rs << 21) + (rt << 16)) | (imm & 32'h0000FFFF);
  endfunction

  // first (or only) word of an instruction; returns 0 for an illegal kind
  function automatic bit enc(input int k, input int rd, input int rs, input int rt, input int sh,
                             input logic [31:0] imm, output logic [31:0] w);
    enc = 1'b1;
    w   = '0;
    case (k)
      0:  w = '0;
      1:  w = rw(rs, rt, rd, sh, 32);
      2:  w = rw(rs, rt, rd, sh, 33);
      3:  w = rw(rs, rt, rd, sh, 34);
      4:  w = rw(rs, rt, rd, sh, 35);
      5:  w = rw(rs, rt, rd, sh, 36);
      6:  w = rw(rs, rt, rd, sh, 37);
      7:  w = rw(rs, rt, rd, sh, 39);
      8:  w = rw(rs, rt, rd, sh, 42);
      9:  w = rw(rs, rt, rd, sh, 0);
      10: w = rw(rs, rt, rd, sh, 2);
      11: w = rw(rs, rt, rd, sh, 3);
      12: w = rw(rs, 0, 0, 0, 8);
      13: w = iw(8, rs, rt, imm);
      14: w = iw(9, rs, rt, imm);
      15: w = iw(12, rs, rt, imm);
      16: w = iw(13, rs, rt, imm);
      17: w = iw(10, rs, rt, imm);
      18: w = iw(15, rs, rt, imm);
      19: w = iw(35, rs, rt, imm);
      20: w = iw(43, rs, rt, imm);
      21: w = iw(4, rs, rt, imm);
      22: w = iw(5, rs, rt, imm);
      23: w = iw(7, rs, 0, imm);
      24: w = iw(1, rs, 1, imm);
      25: w = (32'd2 << 26) | (imm & 32'h03FFFFFF);
      26: w = (32'd3 << 26) | (imm & 32'h03FFFFFF);
      27: if (LI_EN) w = iw(15, 0, rt, imm >> 16); else enc = 1'b0;
      default: enc = 1'b0;
    endcase
  endfunction

  task automatic put(input logic [31:0] w, input bit last);
    e_we   = 1'b1;
    e_addr = BASE + m_used;
    e_data = w;
    m_used++;
    if (m_used == DEP) m_full = 1'b1;
    if (last) begin
      m_used      = 0;
      m_done_pend = 1'b1;
    end
  endtask

  // compare this cycle against the model, log writes, then advance the model over the coming edge
  always @(negedge clk) begin
    bit          rdy, ok;
    logic [31:0] w;
    int          k;
    k   = int'(ifc.in_kind);
    rdy = !rst && !m_full && !m_second && !(LI_EN && k == 27 && (DEP - m_used) == 1);
    if (chk_en) begin
      chk("in_ready", ifc.in_ready, rdy);
      chk("mem_we", ifc.mem_we, e_we);
      chk("mem_addr", ifc.mem_addr, e_addr);
      chk("mem_wdata", ifc.mem_wdata, e_data);
      chk("full", full, m_full);
      chk("done", done, e_done);
      chk("err", err, m_err);
    end
    if (ifc.mem_we) begin
      wlog_data.push_back(ifc.mem_wdata);
      wlog_addr.push_back(int'(ifc.mem_addr));
      wlog_cyc.push_back(cyc);
    end
    if (done) done_cnt++;

    e_done = m_done_pend;
    if (rst) begin
      m_used = 0; m_full = 0; m_err = 0; m_second = 0; m_done_pend = 0;
      e_we = 0; e_done = 0; e_addr = BASE; e_data = '0;
    end else begin
      e_we        = 1'b0;
      m_done_pend = 1'b0;
      if (m_second) begin
        m_second = 1'b0;
        put(m_second_word, m_second_last);
      end else if (ifc.in_valid && rdy) begin
        ok = enc(k, int'(ifc.in_rd), int'(ifc.in_rs), int'(ifc.in_rt), int'(ifc.in_shamt), ifc.in_imm, w);
        if (!ok) begin
          m_err = 1'b1;
          if (ifc.in_last) m_done_pend = 1'b1;
        end else if (LI_EN && k == 27) begin
          put(w, 1'b0);
          m_second      = 1'b1;
          m_second_word = iw(13, int'(ifc.in_rt), int'(ifc.in_rt), ifc.in_imm);
          m_second_last = ifc.in_last;
        end else begin
          put(w, ifc.in_last);
        end
      end
    end
  end

  // all stimulus tasks start and return just after a rising edge
  task automatic send(input int k, input int rd, input int rs, input int rt, input int sh,
                      input logic [31:0] imm, input bit last, output int acc);
    int n;
    n = 0;
    ifc.in_valid = 1'b1;
    ifc.in_kind  = 5'(k);
    ifc.in_rd    = 5'(rd);
    ifc.in_rs    = 5'(rs);
    ifc.in_rt    = 5'(rt);
    ifc.in_shamt = 5'(sh);
    ifc.in_imm   = imm;
    ifc.in_last  = last;
    @(negedge clk);
    while (!ifc.in_ready && n < 40) begin
      n++;
      @(negedge clk);
    end
    acc = cyc;
    if (!ifc.in_ready) begin
      total++;
      bad++;
      $display("FAIL send_timeout kind=%0d in_ready=0 want=1", k);
    end
    @(posedge clk);
    #1;
    ifc.in_valid = 1'b0;
    ifc.in_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    ifc.in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    ifc.in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int n0, d0, a, a2;
    ifc.in_valid = 1'b0; ifc.in_kind = '0; ifc.in_rd = '0; ifc.in_rs = '0;
    ifc.in_rt = '0; ifc.in_shamt = '0; ifc.in_imm = '0; ifc.in_last = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", ifc.in_ready, 0);
    repeat (2) @(posedge clk);
    #1;
    rst    = 1'b0;
    chk_en = 1'b1;
    chk("rst_mem_we", ifc.mem_we, 0);
    chk("rst_mem_addr", ifc.mem_addr, BASE);
    chk("rst_mem_wdata", ifc.mem_wdata, 0);
    chk("rst_flags", {full, done, err}, 0);

    n0 = wlog_data.size();
    send(1, 3, 1, 2, 0, 0, 0, a);
    idle(2);
    chk("add_count", wlog_data.size() - n0, 1);
    chk("add_data", wlog_data[n0], 32'h00221820);
    chk("add_addr", wlog_addr[n0], BASE);
    chk("add_latency", wlog_cyc[n0] - a, 1);

    n0 = wlog_data.size();
    send(19, 0, 29, 8, 0, 32'd4, 0, a);
    send(9, 2, 0, 1, 4, 0, 0, a2);
    idle(2);
    chk("lw_data", wlog_data[n0], 32'h8FA80004);
    chk("lw_addr", wlog_addr[n0], BASE + 1);
    chk("sll_data", wlog_data[n0+1], 32'h00011100);
    chk("sll_addr", wlog_addr[n0+1], BASE + 2);
    chk("b2b_accept_gap", a2 - a, 1);
    chk("b2b_write_gap", wlog_cyc[n0+1] - wlog_cyc[n0], 1);

    n0 = wlog_data.size();
    d0 = done_cnt;
    send(24, 0, 4, 0, 0, 32'hFFFFFFFE, 0, a);
    send(25, 0, 0, 0, 0, 32'h00000100, 1, a);
    idle(4);
    chk("bgez_data", wlog_data[n0], 32'h0481FFFE);
    chk("j_data", wlog_data[n0+1], 32'h08000100);
    chk("j_addr", wlog_addr[n0+1], BASE + 4);
    chk("done_pulses", done_cnt - d0, 1);
    n0 = wlog_data.size();
    send(0, 0, 0, 0, 0, 0, 0, a);
    idle(2);
    chk("ptr_reload_addr", wlog_addr[n0], BASE);

    n0 = wlog_data.size();
    d0 = done_cnt;
    send(30, 1, 2, 3, 4, 32'h1234, 0, a);
    idle(2);
    chk("illegal_err", err, 1);
    chk("illegal_nowrite", wlog_data.size() - n0, 0);
    send(31, 0, 0, 0, 0, 0, 1, a);
    idle(4);
    chk("illegal_last_done", done_cnt - d0, 1);
    chk("err_kept_after_done", err, 1);
    do_reset();
    chk("err_cleared", err, 0);

    n0 = wlog_data.size();
    for (int i = 0; i < DEP; i++) send(0, 0, 0, 0, 0, 0, 0, a);
    chk("fill_full", full, 1);
    ifc.in_valid = 1'b1;
    ifc.in_kind  = 5'd0;
    repeat (4) begin
      @(negedge clk);
      chk("full_holds_ready", ifc.in_ready, 0);
    end
    @(posedge clk);
    #1;
    ifc.in_valid = 1'b0;
    chk("fill_count", wlog_data.size() - n0, DEP);
    chk("fill_last_addr", wlog_addr[n0+DEP-1], BASE + DEP - 1);
    do_reset();

`ifdef INSTR_ENC_LI_EN
    n0 = wlog_data.size();
    send(27, 0, 0, 5, 0, 32'h12345678, 0, a);
    ifc.in_valid = 1'b1;
    ifc.in_kind  = 5'd0;
    @(negedge clk);
    chk("li_gap_ready", ifc.in_ready, 0);
    @(posedge clk);
    #1;
    idle(2);
    chk("li_lui", wlog_data[n0], 32'h3C051234);
    chk("li_ori", wlog_data[n0+1], 32'h34A55678);
    chk("li_consecutive", wlog_cyc[n0+1] - wlog_cyc[n0], 1);

    n0 = wlog_data.size();
    send(27, 0, 0, 7, 0, 32'hCAFEF00D, 0, a);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("li_rst_outputs", {ifc.mem_we, full, done, err}, 0);
    chk("li_rst_addr", ifc.mem_addr, BASE);
    chk("li_rst_wdata", ifc.mem_wdata, 0);
    idle(2);
    chk("li_rst_drops_ori", wlog_data.size() - n0, 1);
    n0 = wlog_data.size();
    send(0, 0, 0, 0, 0, 0, 0, a);
    idle(2);
    chk("li_rst_next_addr", wlog_addr[n0], BASE);

    do_reset();
    for (int i = 0; i < DEP - 1; i++) send(0, 0, 0, 0, 0, 0, 0, a);
    ifc.in_valid = 1'b1;
    ifc.in_kind  = 5'd27;
    repeat (3) begin
      @(negedge clk);
      chk("li_one_slot_ready", ifc.in_ready, 0);
    end
    @(posedge clk);
    #1;
    send(0, 0, 0, 0, 0, 0, 0, a);
    chk("li_one_slot_then_full", full, 1);
    do_reset();
`endif

    for (int i = 0; i < 3000; i++) begin
      rst          = ($urandom_range(0, 149) == 0) || (m_full && $urandom_range(0, 5) == 0);
      ifc.in_valid = ($urandom_range(0, 3) != 0);
      ifc.in_kind  = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 27));
      ifc.in_rd    = 5'($urandom);
      ifc.in_rs    = 5'($urandom);
      ifc.in_rt    = 5'($urandom);
      ifc.in_shamt = 5'($urandom);
      ifc.in_imm   = $urandom;
      ifc.in_last  = ($urandom_range(0, 9) == 0);
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    idle(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
